seq_mult_ctrl: RTL and testbench

Sequential shift-and-add multiplier controller that time-shares a single WIDTH-bit ripple adder across WIDTH iterations to form an unsigned 2·WIDTH-bit product. It sits beside the combinational multiplier in the mult_8bit area as its low-area alternative. It sequences operand capture, per-bit conditional add, shift, and result hand-off under a start/busy/done handshake.

---
 rtl/mult_pkg.sv | 17 +
 rtl/seq_mult_ctrl_if.sv | 18 +
 rtl/add_ripple.sv | 24 ++
 rtl/seq_mult_ctrl.sv | 88 ++++++++
 tb/tb_seq_mult_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int WIDTH_DEF = 8;

  // Iteration counter width: wide enough to hold WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Start/busy/done handshake bundle between a requester and the multiplier.
interface seq_mult_ctrl_if
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/add_ripple.sv
// WIDTH-bit ripple-carry adder: a half adder at bit 0 feeding a chain of full adders.
module add_ripple #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Ripple the carry from LSB to MSB, one full-adder cell per bit.
  always_comb begin
    logic carry;
    // NOTE: every combinational output gets a value before any branch, so no latch is inferred.
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add multiplier: one shared adder, WIDTH iterations per product.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  seq_mult_ctrl_if.slave   bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mlier_q;
  logic [WIDTH-1:0]     acc_hi_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 carry;
  logic [2*WIDTH-1:0]   shifted;
  logic                 last_iter;
  logic                 accept;

  // Only the multiplicand is added, and only when the current multiplier LSB is set.
  assign addend    = mlier_q[0] ? mcand_q : '0;
  assign shifted   = {carry, sum, mlier_q[WIDTH-1:1]};
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign accept    = bus.start && (state_q != RUN);

  add_ripple #(.WIDTH(WIDTH)) u_add (
    .a    (acc_hi_q),
    .b    (addend),
    .sum  (sum),
    .cout (carry)
  );

  // Next-state logic: RUN is uninterruptible; DONE behaves like IDLE for a new start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and datapath registers; capture on accept, add-and-shift while running.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mlier_q  <= '0;
      acc_hi_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mcand_q  <= bus.a;
        mlier_q  <= bus.b;
        acc_hi_q <= '0;
        cnt_q    <= '0;
      end else if (state_q == RUN) begin
        {acc_hi_q, mlier_q} <= shifted;
        cnt_q               <= cnt_q + 1'b1;
      end
    end
  end

  // Result register: loads on the final iteration; a reset that aborts a run keeps the old result.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q != RUN) product_q <= '0;
    end else if (state_q == RUN && last_iter) begin
      product_q <= shifted;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl: behavioural model plus directed literal cases.
module tb_seq_mult_ctrl;
  import mult_pkg::*;

  localparam int WIDTH = WIDTH_DEF;
  localparam int PW    = 2 * WIDTH;
  localparam int LAT   = WIDTH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

  seq_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted request yields a*b exactly WIDTH cycles later.
  int              run_left = 0;
  logic [PW-1:0]   pend     = '0;
  logic [PW-1:0]   m_prod   = '0;
  logic            m_done   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      if (run_left == 0) m_prod <= '0;
      run_left <= 0;
      m_done   <= 1'b0;
    end else if (run_left > 0) begin
      run_left <= run_left - 1;
      if (run_left == 1) begin
        m_done <= 1'b1;
        m_prod <= pend;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        run_left <= WIDTH;
        pend     <= PW'(bus.a) * PW'(bus.b);
      end
    end
  end

  // Compare process: every cycle once out of the initial reset.
  bit cmp_en     = 1'b0;
  int done_count = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", bus.busy, run_left > 0);
      check("done", bus.done, m_done);
      check("product", bus.product, m_prod);
      check("busy_done_excl", bus.busy & bus.done, 1'b0);
      if (bus.done) done_count++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle start, then scramble the now don't-care operands.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
  endtask

  // Wait for a done pulse with a bounded budget; lat counts negedges waited.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      lat = i;
      if (bus.done) break;
    end
    if (!bus.done) check("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [PW-1:0] exp);
    int lat;
    issue(a, b);
    wait_done(lat);
    check({name, "_latency"}, lat + 1, LAT);
    check(name, bus.product, exp);
    cyc(2);
    check({name, "_hold"}, bus.product, exp);
  endtask

  initial begin
    int lat;
    int d0;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset then idle.
    cyc(2);
    rst    = 1'b0;
    cmp_en = 1'b1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_product", bus.product, 16'h0000);
    done_count = 0;
    cyc(20);
    check("idle_no_done", done_count, 0);

    // Basic multiply and corner values.
    run_op("basic", 8'h0D, 8'h0B, 16'h008F);
    run_op("ff_ff", 8'hFF, 8'hFF, 16'hFE01);
    run_op("00_a5", 8'h00, 8'hA5, 16'h0000);
    run_op("80_02", 8'h80, 8'h02, 16'h0100);
    run_op("01_ff", 8'h01, 8'hFF, 16'h00FF);

    // Start while busy is ignored.
    d0 = done_count;
    issue(8'h06, 8'h07);
    cyc(2);
    bus.start = 1'b1;
    bus.a     = 8'h02;
    bus.b     = 8'h02;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    check("busy_start_product", bus.product, 16'h002A);
    cyc(12);
    check("busy_start_one_done", done_count - d0, 1);

    // Reset mid-operation keeps the previous result and emits no done.
    issue(8'h0C, 8'h05);
    cyc(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_product", bus.product, 16'h002A);
    d0 = done_count;
    cyc(15);
    check("abort_no_done", done_count - d0, 0);
    run_op("after_abort", 8'h03, 8'h05, 16'h000F);

    // Back-to-back: start held during DONE.
    issue(8'h0C, 8'h0C);
    wait_done(lat);
    check("b2b_first", bus.product, 16'h0090);
    bus.start = 1'b1;
    bus.a     = 8'h07;
    bus.b     = 8'h09;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    check("b2b_spacing", lat + 1, LAT);
    check("b2b_second", bus.product, 16'h003F);

    // Randomized traffic: sporadic starts, occasional resets, checked by the model.
    for (int i = 0; i < 600; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
      rst       = ($urandom_range(0, 60) == 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    cyc(WIDTH + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
